a2_ex_wb_fwd_stage: RTL and testbench
=====================================

Name: a2_ex_wb_fwd_stage

Overview:
- EX/WB pipeline register for the 8-bit datapath, with writeback-to-operand forwarding control.
- Captures the EX-stage result, destination register and write enable each cycle.
- Drives the select and d1 inputs of the downstream 8-bit 2:1 operand muxes: d0 = register-file read, d1 = forwarded WB result.
- Handles stall, flush and register-0 suppression, and keeps a saturating forwarding-hit counter for debug.

Parameters:
- DATA_W, 8, width of datapath result.
- ADDR_W, 3, width of register address (8 registers; r0 hardwired to zero).
- CNT_W, 8, width of the forwarding-hit counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold WB register contents this cycle
- flush  input  1  invalidate WB register at next edge
- ex_valid  input  1  EX stage holds a valid instruction
- ex_result  input  DATA_W  EX-stage ALU result
- ex_rd  input  ADDR_W  EX-stage destination register
- ex_regwr  input  1  EX-stage register-write enable
- id_rs1  input  ADDR_W  source register A of instruction in ID/EX
- id_rs2  input  ADDR_W  source register B of instruction in ID/EX
- wb_valid  output  1  WB register valid
- wb_result  output  DATA_W  registered result (also forwarded data, to mux d1)
- wb_rd  output  ADDR_W  registered destination register
- wb_regwr  output  1  register-file write enable, qualified by wb_valid
- fwd_sel_a  output  1  select for operand-A mux (1 = forward wb_result)
- fwd_sel_b  output  1  select for operand-B mux (1 = forward wb_result)
- fwd_hits  output  CNT_W  saturating count of cycles with any forward

Behaviour:
- Reset (rst_n low, asynchronous, any time): wb_valid=0, wb_result=0, wb_rd=0, internal regwr=0, fwd_hits=0.
  - All outputs read 0 while reset is held, and for the first cycle after release.
- Register update on rising clk edge, priority flush > stall > load:
  - flush=1: wb_valid<=0, internal regwr<=0; wb_result and wb_rd hold. flush overrides stall.
  - stall=1, flush=0: all WB registers hold.
  - Otherwise: wb_valid<=ex_valid, wb_result<=ex_result, wb_rd<=ex_rd, internal regwr<=ex_regwr & ex_valid.
- Latency: EX inputs appear on the wb_* outputs exactly 1 cycle later.
- wb_regwr = wb_valid & internal regwr (combinational). It is never 1 while wb_valid=0.
- Forwarding (combinational from registered state plus id_rs*):
  - fwd_sel_a = wb_regwr & (wb_rd != 0) & (wb_rd == id_rs1).
  - fwd_sel_b = same with id_rs2.
  - Both may be 1 simultaneously when id_rs1 == id_rs2 == wb_rd.
  - Writes to r0 never forward.
- Forwarded data is wb_result itself, connected to d1 of both muxes. The block does not drive d0.
- Hit counter:
  - On a rising edge with stall=0, fwd_hits increments by 1 if (fwd_sel_a | fwd_sel_b). Count is 1 per cycle, not per operand.
  - Saturates at 2^CNT_W-1 (255); holds there.
  - Held during stall. Not cleared by flush; cleared only by reset.
- Stall plus forwarding: the sel outputs stay live during stall. They track id_rs* changes against the held wb_rd.
- Reset deasserted mid-stream: the first valid capture is at the first edge after rst_n rises, if stall=0.

Test Plan:
- Reset check: rst_n=0 with ex_valid=1, ex_result=8'hAA driven -> wb_valid=0, wb_result=0, fwd_sel_a/b=0, fwd_hits=0. After release plus 1 edge -> wb_result=8'hAA, wb_valid=1.
- Single forward: ex_result=8'd20, ex_rd=3, ex_regwr=1, ex_valid=1, then id_rs1=3, id_rs2=5 -> next cycle fwd_sel_a=1, fwd_sel_b=0, wb_result=20. fwd_hits goes 0->1 on the following edge.
- Dual and r0: ex_rd=2, id_rs1=id_rs2=2 -> both sels 1. Repeat with ex_rd=0, id_rs1=0 -> both sels 0, wb_regwr=1 (write to r0 still issued).
- Flush vs stall: load ex_result=8'd30, ex_rd=4; assert stall=1 and flush=1 together -> next edge wb_valid=0, wb_regwr=0, fwd_sel_a=0 with id_rs1=4, wb_result still 30. Stall alone for 3 cycles -> wb_* held, fwd_hits unchanged.
- Invalid write suppressed: ex_valid=0, ex_regwr=1, ex_rd=6, id_rs1=6 -> wb_regwr=0, fwd_sel_a=0.
- Counter saturation: continuous forwarding for 300 unstalled cycles -> fwd_hits=255 and stays at 255. Async reset mid-run -> fwd_hits=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/a2_ex_wb_fwd_stage.sv
// EX/WB pipeline register with writeback-to-operand forwarding selects and a
// saturating forwarding-hit counter for debug.
module a2_ex_wb_fwd_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_regwr,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_result,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              wb_regwr,
    output logic              fwd_sel_a,
    output logic              fwd_sel_b,
    output logic [CNT_W-1:0]  fwd_hits
);

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_rd;
    logic              r_regwr;
    logic [CNT_W-1:0]  r_hits;

    logic              w_regwr;
    logic              w_rd_nonzero;
    logic              w_fwd_a;
    logic              w_fwd_b;

    // Flush only kills valid/regwr; the stale result and rd stay for debug visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_regwr  <= 1'b0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_regwr  <= 1'b0;
        end else if (!stall) begin
            r_valid  <= ex_valid;
            r_result <= ex_result;
            r_rd     <= ex_rd;
            r_regwr  <= ex_regwr & ex_valid;
        end
    end

    assign w_regwr      = r_valid & r_regwr;
    assign w_rd_nonzero = (r_rd != '0);
    assign w_fwd_a      = w_regwr & w_rd_nonzero & (r_rd == id_rs1);
    assign w_fwd_b      = w_regwr & w_rd_nonzero & (r_rd == id_rs2);

    // One count per cycle with any forward, regardless of how many operands hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits <= '0;
        end else if (!stall && (w_fwd_a || w_fwd_b) && (r_hits != {CNT_W{1'b1}})) begin
            r_hits <= r_hits + 1'b1;
        end
    end

    assign wb_valid  = r_valid;
    assign wb_result = r_result;
    assign wb_rd     = r_rd;
    assign wb_regwr  = w_regwr;
    assign fwd_sel_a = w_fwd_a;
    assign fwd_sel_b = w_fwd_b;
    assign fwd_hits  = r_hits;

endmodule

// File: tb/tb_a2_ex_wb_fwd_stage.sv
// Directed bench for a2_ex_wb_fwd_stage: reset, table of single-edge vectors,
// then counter saturation and asynchronous reset sequences.
module tb_a2_ex_wb_fwd_stage;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_regwr;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_result;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_regwr;
    logic              fwd_sel_a;
    logic              fwd_sel_b;
    logic [CNT_W-1:0]  fwd_hits;

    int checks_total;
    int checks_passed;

    a2_ex_wb_fwd_stage #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .ex_valid (ex_valid),
        .ex_result(ex_result),
        .ex_rd    (ex_rd),
        .ex_regwr (ex_regwr),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .wb_valid (wb_valid),
        .wb_result(wb_result),
        .wb_rd    (wb_rd),
        .wb_regwr (wb_regwr),
        .fwd_sel_a(fwd_sel_a),
        .fwd_sel_b(fwd_sel_b),
        .fwd_hits (fwd_hits)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic              stall;
        logic              flush;
        logic              ex_valid;
        logic [DATA_W-1:0] ex_result;
        logic [ADDR_W-1:0] ex_rd;
        logic              ex_regwr;
        logic [ADDR_W-1:0] id_rs1;
        logic [ADDR_W-1:0] id_rs2;
        logic              e_valid;
        logic [DATA_W-1:0] e_result;
        logic [ADDR_W-1:0] e_rd;
        logic              e_regwr;
        logic              e_sel_a;
        logic              e_sel_b;
        logic [CNT_W-1:0]  e_hits;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_v, input logic [DATA_W-1:0] e_res,
                             input logic [ADDR_W-1:0] e_rd, input logic e_wr, input logic e_sa,
                             input logic e_sb, input logic [CNT_W-1:0] e_h);
        check({tag, ".wb_valid"},  32'(wb_valid),  32'(e_v));
        check({tag, ".wb_result"}, 32'(wb_result), 32'(e_res));
        check({tag, ".wb_rd"},     32'(wb_rd),     32'(e_rd));
        check({tag, ".wb_regwr"},  32'(wb_regwr),  32'(e_wr));
        check({tag, ".fwd_sel_a"}, 32'(fwd_sel_a), 32'(e_sa));
        check({tag, ".fwd_sel_b"}, 32'(fwd_sel_b), 32'(e_sb));
        check({tag, ".fwd_hits"},  32'(fwd_hits),  32'(e_h));
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic [DATA_W-1:0] res,
                         input logic [ADDR_W-1:0] rd, input logic wr,
                         input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2);
        stall     = s;
        flush     = f;
        ex_valid  = v;
        ex_result = res;
        ex_rd     = rd;
        ex_regwr  = wr;
        id_rs1    = rs1;
        id_rs2    = rs2;
    endtask

    task automatic add_vec(input logic s, input logic f, input logic v, input logic [DATA_W-1:0] res,
                           input logic [ADDR_W-1:0] rd, input logic wr,
                           input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                           input logic ev, input logic [DATA_W-1:0] eres,
                           input logic [ADDR_W-1:0] erd, input logic ewr,
                           input logic esa, input logic esb, input logic [CNT_W-1:0] eh);
        vec_t t;
        t = '{s, f, v, res, rd, wr, rs1, rs2, ev, eres, erd, ewr, esa, esb, eh};
        vecs.push_back(t);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;

        // Each row: inputs driven at negedge, outputs checked 1ns after the next posedge.
        // Expected hits use the pre-edge WB state against this row's id_rs*.
        //       s  f  v  res    rd wr rs1 rs2 | v  res    rd wr sa sb hits
        add_vec(0, 0, 1, 8'd20, 3, 1, 3, 5,    1, 8'd20, 3, 1, 1, 0, 8'd0); // single forward
        add_vec(0, 0, 1, 8'd21, 2, 1, 3, 5,    1, 8'd21, 2, 1, 0, 0, 8'd1); // hit counted on this edge
        add_vec(0, 0, 1, 8'd22, 2, 1, 2, 2,    1, 8'd22, 2, 1, 1, 1, 8'd2); // dual forward
        add_vec(0, 0, 1, 8'd23, 0, 1, 0, 0,    1, 8'd23, 0, 1, 0, 0, 8'd2); // r0 never forwards
        add_vec(0, 0, 0, 8'd66, 6, 1, 6, 0,    0, 8'd66, 6, 0, 0, 0, 8'd2); // invalid write suppressed
        add_vec(0, 0, 1, 8'd30, 4, 1, 4, 1,    1, 8'd30, 4, 1, 1, 0, 8'd2);
        add_vec(1, 1, 1, 8'd99, 5, 1, 4, 4,    0, 8'd30, 4, 0, 0, 0, 8'd2); // flush beats stall
        add_vec(0, 0, 1, 8'd40, 4, 1, 4, 7,    1, 8'd40, 4, 1, 1, 0, 8'd2);
        add_vec(1, 0, 1, 8'd77, 7, 1, 4, 4,    1, 8'd40, 4, 1, 1, 1, 8'd2); // stall: hold, no count
        add_vec(1, 0, 1, 8'd77, 7, 1, 7, 4,    1, 8'd40, 4, 1, 0, 1, 8'd2);
        add_vec(1, 0, 1, 8'd77, 7, 1, 1, 1,    1, 8'd40, 4, 1, 0, 0, 8'd2);
        add_vec(0, 0, 1, 8'd50, 1, 1, 1, 1,    1, 8'd50, 1, 1, 1, 1, 8'd2);
        add_vec(0, 1, 1, 8'd60, 5, 1, 1, 3,    0, 8'd50, 1, 0, 0, 0, 8'd3); // flush still counts

        // Reset held with live EX inputs
        rst_n = 1'b0;
        drive(0, 0, 1, 8'hAA, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_held", 0, 8'h00, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset_released", 0, 8'h00, 0, 0, 0, 0, 8'd0);
        @(posedge clk);
        #1;
        check_all("first_capture", 1, 8'hAA, 1, 0, 0, 0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].flush, vecs[i].ex_valid, vecs[i].ex_result,
                  vecs[i].ex_rd, vecs[i].ex_regwr, vecs[i].id_rs1, vecs[i].id_rs2);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_result, vecs[i].e_rd,
                      vecs[i].e_regwr, vecs[i].e_sel_a, vecs[i].e_sel_b, vecs[i].e_hits);
        end

        // Saturation: hits is 3, first edge sees wb_valid=0, every later edge forwards.
        @(negedge clk);
        drive(0, 0, 1, 8'd55, 5, 1, 5, 0);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (c == 100) check("sat_mid.fwd_hits", 32'(fwd_hits), 32'd102);
        end
        check("sat_300.fwd_hits", 32'(fwd_hits), 32'd255);
        check("sat_300.fwd_sel_a", 32'(fwd_sel_a), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold.fwd_hits", 32'(fwd_hits), 32'd255);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 8'h00, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_async", 1, 8'd55, 5, 1, 1, 0, 8'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
